// File: rtl/mseq_pkg.sv
// Shared definitions for the m-sequence generator and its receive-side synchroniser.
package mseq_pkg;

  localparam int unsigned MSEQ_W      = 5;
  localparam int unsigned MSEQ_PERIOD = 31;
  localparam int unsigned CNT_W       = 6;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } mseq_state_t;

  // Feedback bit of the recurrence: parity of the tapped state bits.
  function automatic logic mseq_pred(input logic [MSEQ_W-1:0] state,
                                     input logic [MSEQ_W-1:0] taps);
    return ^(state & taps);
  endfunction

  // Full recurrence step; the generator shifts its own feedback bit in.
  function automatic logic [MSEQ_W-1:0] mseq_next(input logic [MSEQ_W-1:0] state,
                                                  input logic [MSEQ_W-1:0] taps);
    return {state[MSEQ_W-2:0], mseq_pred(state, taps)};
  endfunction

endpackage

// File: rtl/mseq_err_win.sv
// Lock-tracking window: counts valid bits and prediction errors per window
// and flags the window end together with the error-threshold compare.
module mseq_err_win
  import mseq_pkg::*;
#(
  parameter int unsigned WIN_LEN  = MSEQ_PERIOD,
  parameter int unsigned LOSS_THR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic             err_i,
  output logic             win_end_c_o,
  output logic             over_thr_c_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(LOSS_THR);

  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] win_inc_c, err_inc_c;

  // Incremented counts for this bit; the error count saturates at its maximum.
  always_comb begin
    win_inc_c = win_cnt_q + CNT_W'(1);
    err_inc_c = err_cnt_q;
    if (err_i && (err_cnt_q != CNT_MAX)) begin
      err_inc_c = err_cnt_q + CNT_W'(1);
    end
    win_end_c_o  = adv_i && (win_inc_c == WIN_LAST);
    over_thr_c_o = (err_inc_c > THR);
  end

  // Counter next state: cleared outside LOCK and at every window boundary.
  always_comb begin
    win_cnt_d = win_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr_i) begin
      win_cnt_d = '0;
      err_cnt_d = '0;
    end else if (adv_i) begin
      if (win_end_c_o) begin
        win_cnt_d = '0;
        err_cnt_d = '0;
      end else begin
        win_cnt_d = win_inc_c;
        err_cnt_d = err_inc_c;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/mseq_sync.sv
// Receive-side m-sequence synchroniser: self-synchronises a local LFSR from
// the received bits, verifies a run of predictions, then tracks lock.
module mseq_sync
  import mseq_pkg::*;
#(
  parameter int unsigned VERIFY_LEN = MSEQ_PERIOD,
  parameter int unsigned WIN_LEN    = MSEQ_PERIOD,
  parameter int unsigned LOSS_THR   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic [MSEQ_W-1:0] type_f,
  output logic              locked,
  output logic [MSEQ_W-1:0] phase,
  output logic              bit_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              lock_lost
);

  localparam int unsigned      FILL_W    = 3;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(MSEQ_W - 1);
  localparam logic [CNT_W-1:0]  OK_LAST   = CNT_W'(VERIFY_LEN - 1);

  mseq_state_t       state_q, state_d;
  logic [MSEQ_W-1:0] taps_q;
  logic [MSEQ_W-1:0] lfsr_q, lfsr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  ok_q, ok_d;
  logic              locked_q, locked_d;
  logic              bit_err_q, bit_err_d;
  logic              lock_lost_q, lock_lost_d;

  logic              tap_chg_c;
  logic              adv_c;
  logic              pred_c;
  logic              mis_c;
  logic [MSEQ_W-1:0] shift_c;
  logic              err_clr_c;
  logic              err_adv_c;
  logic              win_end_c;
  logic              over_thr_c;

  // Per-cycle decode: tap change, prediction and received-bit shift.
  always_comb begin
    tap_chg_c = (type_f != taps_q);
    adv_c     = bit_valid && !tap_chg_c;
    pred_c    = mseq_pred(lfsr_q, taps_q);
    mis_c     = bit_in ^ pred_c;
    shift_c   = {lfsr_q[MSEQ_W-2:0], bit_in};
    err_clr_c = tap_chg_c || (state_q != LOCK);
    err_adv_c = adv_c && (state_q == LOCK);
  end

  mseq_err_win #(
    .WIN_LEN  (WIN_LEN),
    .LOSS_THR (LOSS_THR)
  ) u_err_win (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (err_clr_c),
    .adv_i        (err_adv_c),
    .err_i        (mis_c),
    .win_end_c_o  (win_end_c),
    .over_thr_c_o (over_thr_c),
    .err_cnt_o    (err_cnt)
  );

  // Tap register: follows type_f; any change restarts acquisition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q <= type_f;
    end else if (tap_chg_c) begin
      taps_q <= type_f;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACQ;
      lfsr_q  <= '0;
      fill_q  <= '0;
      ok_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      fill_q  <= fill_d;
      ok_q    <= ok_d;
    end
  end

  // Next state: fill, verify and lock tracking; a tap change discards the bit.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    fill_d  = fill_q;
    ok_d    = ok_q;
    if (tap_chg_c) begin
      state_d = ACQ;
      fill_d  = '0;
      ok_d    = '0;
    end else if (bit_valid) begin
      lfsr_d = shift_c;
      case (state_q)
        ACQ: begin
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            ok_d   = '0;
            // All-zero is the LFSR lock-up state, so it never seeds VERIFY.
            if (shift_c != '0) begin
              state_d = VERIFY;
            end
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          if (mis_c) begin
            state_d = ACQ;
            fill_d  = '0;
            ok_d    = '0;
          end else if (ok_q == OK_LAST) begin
            state_d = LOCK;
            ok_d    = '0;
          end else begin
            ok_d = ok_q + CNT_W'(1);
          end
        end
        LOCK: begin
          if (win_end_c && over_thr_c) begin
            state_d = ACQ;
            fill_d  = '0;
          end
        end
        default: begin
          state_d = ACQ;
          fill_d  = '0;
          ok_d    = '0;
        end
      endcase
    end
  end

  // Output decode, registered below so all outputs share the sampling edge.
  always_comb begin
    locked_d    = (state_d == LOCK);
    bit_err_d   = adv_c && mis_c && ((state_q == VERIFY) || (state_q == LOCK));
    lock_lost_d = (state_q == LOCK) && (state_d == ACQ);
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      locked_q    <= locked_d;
      bit_err_q   <= bit_err_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign locked    = locked_q;
  assign phase     = lfsr_q;
  assign bit_err   = bit_err_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_mseq_sync.sv
// Directed bench for mseq_sync with a reference model feeding a scoreboard queue.
module tb_mseq_sync;

  localparam int unsigned VLEN = 31;
  localparam int unsigned WLEN = 31;
  localparam int unsigned THR  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in;
  logic       bit_valid;
  logic [4:0] type_f;
  logic       locked;
  logic [4:0] phase;
  logic       bit_err;
  logic [5:0] err_cnt;
  logic       lock_lost;

  always #5 clk = ~clk;

  mseq_sync #(
    .VERIFY_LEN (VLEN),
    .WIN_LEN    (WLEN),
    .LOSS_THR   (THR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .type_f    (type_f),
    .locked    (locked),
    .phase     (phase),
    .bit_err   (bit_err),
    .err_cnt   (err_cnt),
    .lock_lost (lock_lost)
  );

  typedef struct packed {
    logic       locked;
    logic [4:0] phase;
    logic       bit_err;
    logic [5:0] err_cnt;
    logic       lock_lost;
  } obs_t;

  obs_t  exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  string step_tag = "init";

  // Reference model state (0=ACQ, 1=VERIFY, 2=LOCK).
  int         m_st, m_fill, m_ok, m_win, m_err;
  logic [4:0] m_lfsr, m_taps;
  // Transmitter (mfun) state.
  logic [4:0] gen;

  function automatic obs_t dut_obs();
    obs_t o;
    o.locked    = locked;
    o.phase     = phase;
    o.bit_err   = bit_err;
    o.err_cnt   = err_cnt;
    o.lock_lost = lock_lost;
    return o;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", step_tag, tag, got, want);
    end
  endtask

  task automatic check_obs(input obs_t got, input obs_t want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s/sb: observed lk=%b ph=%b be=%b ec=%0d ll=%b expected lk=%b ph=%b be=%b ec=%0d ll=%b",
             step_tag, got.locked, got.phase, got.bit_err, got.err_cnt, got.lock_lost,
             want.locked, want.phase, want.bit_err, want.err_cnt, want.lock_lost);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_ok = 0; m_win = 0; m_err = 0;
    m_lfsr = 5'b0;
    m_taps = type_f;
    exp_q.delete();
  endtask

  task automatic model_step(input logic b, input logic v, input logic [4:0] tf, output obs_t e);
    logic       p;
    logic [4:0] sh;
    e.bit_err   = 1'b0;
    e.lock_lost = 1'b0;
    if (tf != m_taps) begin
      if (m_st == 2) e.lock_lost = 1'b1;
      m_taps = tf; m_st = 0; m_fill = 0; m_ok = 0; m_win = 0; m_err = 0;
    end else if (v) begin
      p  = ^(m_lfsr & m_taps);
      sh = {m_lfsr[3:0], b};
      case (m_st)
        0: begin
          m_fill++;
          if (m_fill == 5) begin
            m_fill = 0;
            if (sh != 5'b0) begin m_st = 1; m_ok = 0; end
          end
        end
        1: begin
          if (b != p) begin
            e.bit_err = 1'b1; m_st = 0; m_fill = 0; m_ok = 0;
          end else begin
            m_ok++;
            if (m_ok == VLEN) begin m_st = 2; m_ok = 0; m_win = 0; m_err = 0; end
          end
        end
        default: begin
          m_win++;
          if (b != p) begin
            e.bit_err = 1'b1;
            if (m_err < 63) m_err++;
          end
          if (m_win == WLEN) begin
            if (m_err > THR) begin e.lock_lost = 1'b1; m_st = 0; m_fill = 0; end
            m_win = 0; m_err = 0;
          end
        end
      endcase
      m_lfsr = sh;
    end
    e.locked  = (m_st == 2);
    e.phase   = m_lfsr;
    e.err_cnt = 6'(m_err);
  endtask

  // One clock: drive, push expectation, sample 1 time unit after the edge, pop and compare.
  task automatic cycle(input logic b, input logic v);
    obs_t e;
    obs_t want;
    bit_in    = b;
    bit_valid = v;
    model_step(b, v, type_f, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check_obs(dut_obs(), want);
  endtask

  task automatic send_bit(input logic flip);
    logic b;
    b   = ^(gen & type_f);
    gen = {gen[3:0], b};
    cycle(b ^ flip, 1'b1);
  endtask

  task automatic send_clean(input int n);
    repeat (n) send_bit(1'b0);
  endtask

  task automatic do_reset();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_locked", 16'(locked), 16'(0));
    check("rst_phase", 16'(phase), 16'(0));
    check("rst_err", 16'({bit_err, err_cnt, lock_lost}), 16'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    logic v;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    type_f    = 5'b11101;
    #1;

    // Reset state
    step_tag = "reset";
    do_reset();

    // Clean lock with taps 11101 from fase 10101
    step_tag = "clean";
    gen = 5'b10101;
    send_clean(35);
    check("no_lock_35", 16'(locked), 16'(0));
    send_clean(1);
    check("lock_36", 16'(locked), 16'(1));
    check("phase_36", 16'(phase), 16'(gen));

    // Single flipped bit at window position 30: lock survives both windows
    step_tag = "isolated";
    send_clean(29);
    send_bit(1'b1);
    check("iso_bit_err", 16'(bit_err), 16'(1));
    check("iso_err_cnt", 16'(err_cnt), 16'(1));
    check("iso_locked", 16'(locked), 16'(1));
    send_clean(1);
    check("iso_win_end_cnt", 16'(err_cnt), 16'(0));
    check("iso_win_end_lock", 16'(locked), 16'(1));
    send_clean(31);
    check("iso_next_win_cnt", 16'(err_cnt), 16'(0));
    check("iso_next_win_lock", 16'(locked), 16'(1));

    // Five spaced flips in one window: 25 errors, loss at window end only
    step_tag = "loss";
    for (int w = 1; w <= 31; w++) begin
      send_bit((w == 1) || (w == 7) || (w == 13) || (w == 19) || (w == 25));
      if (w == 30) begin
        check("loss_still_locked", 16'(locked), 16'(1));
        check("loss_err_cnt_30", 16'(err_cnt), 16'(25));
      end
    end
    check("loss_pulse", 16'(lock_lost), 16'(1));
    check("loss_unlocked", 16'(locked), 16'(0));
    send_clean(1);
    check("loss_pulse_end", 16'(lock_lost), 16'(0));
    send_clean(34);
    check("relock_35", 16'(locked), 16'(0));
    send_clean(1);
    check("relock_36", 16'(locked), 16'(1));

    // Flip of stream bit 10 during VERIFY delays lock by 10 bits
    step_tag = "verify_fail";
    do_reset();
    gen = 5'b10101;
    send_clean(9);
    send_bit(1'b1);
    check("vf_bit_err", 16'(bit_err), 16'(1));
    send_clean(35);
    check("vf_no_lock_45", 16'(locked), 16'(0));
    send_clean(1);
    check("vf_lock_46", 16'(locked), 16'(1));

    // All-zero stream never leaves ACQ
    step_tag = "zero";
    do_reset();
    repeat (80) cycle(1'b0, 1'b1);
    check("zero_locked", 16'(locked), 16'(0));
    check("zero_phase", 16'(phase), 16'(0));

    // Random gaps in bit_valid: lock after the 36th valid bit
    step_tag = "gaps";
    do_reset();
    gen  = 5'b10101;
    vcnt = 0;
    for (int c = 0; (c < 1000) && (vcnt < 36); c++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        vcnt++;
        send_bit(1'b0);
        if (vcnt == 35) check("gap_no_lock_35", 16'(locked), 16'(0));
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'b0);
      end
    end
    check("gap_budget", 16'(vcnt), 16'(36));
    check("gap_lock_36", 16'(locked), 16'(1));
    repeat (3) cycle(1'b1, 1'b0);
    check("gap_freeze_phase", 16'(phase), 16'(gen));

    // Tap change while locked, coincident with a valid bit that gets discarded
    step_tag = "tap_change";
    type_f = 5'b10111;
    cycle(1'b1, 1'b1);
    check("tap_lock_lost", 16'(lock_lost), 16'(1));
    check("tap_unlocked", 16'(locked), 16'(0));
    check("tap_phase_kept", 16'(phase), 16'(gen));
    cycle(1'b0, 1'b0);
    check("tap_pulse_end", 16'(lock_lost), 16'(0));
    send_clean(35);
    check("tap_no_lock_35", 16'(locked), 16'(0));
    send_clean(1);
    check("tap_relock_36", 16'(locked), 16'(1));

    // Asynchronous reset mid-LOCK
    step_tag = "rst_mid_lock";
    bit_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("amid_locked", 16'(locked), 16'(0));
    check("amid_phase", 16'(phase), 16'(0));
    check("amid_pulses", 16'({bit_err, err_cnt, lock_lost}), 16'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0);
    check("amid_no_lost", 16'(lock_lost), 16'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
